// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage behind the async FIFO (rclk domain).
// Issues FIFO reads and absorbs the one-cycle read latency in a 2-entry
// in-order buffer. Presents the words as a valid/ready stream that is framed
// into PKT_LEN-beat packets, and counts the completed packets.
module fifo_rd_stream #(
  parameter  int D_WIDTH = 8,
  parameter  int PKT_LEN = 4,
  parameter  int CNT_W   = 16,
  localparam int BEAT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] fifo_rd_data,
  input  logic               fifo_empty,
  output logic               fifo_r_en,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [BEAT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]   pkt_cnt
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  // buffer occupancy (0..2) and the read issued last cycle whose data is due now
  logic [1:0]         occ_q, occ_d;
  logic               inflight_q, inflight_d;
  logic [D_WIDTH-1:0] head_q, head_d;
  logic [D_WIDTH-1:0] tail_q, tail_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   pkt_q, pkt_d;

  logic       pop;
  logic       wr;
  logic [2:0] fill;

  // Handshake and read issue. A pop in this cycle frees a slot, so a new
  // read may be issued even while the buffer plus in-flight word total two.
  always_comb begin
    pop       = (occ_q != 2'd0) & m_ready;
    wr        = inflight_q;
    fill      = {1'b0, occ_q} + {2'b00, inflight_q};
    fifo_r_en = ~reset & ~fifo_empty & ((fill < 3'd2) | pop);
  end

  // Buffer update: the head always holds the oldest word; writes land in the
  // first free slot after the head, accounting for a same-cycle pop.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_r_en;
    case ({pop, wr})
      2'b01: begin
        if (occ_q == 2'd0) begin
          head_d = fifo_rd_data;
        end else begin
          tail_d = fifo_rd_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_rd_data;
        end else begin
          head_d = tail_q;
          tail_d = fifo_rd_data;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Packet framing: beat index advances on every delivered word and wraps on
  // the final beat, at which point the completed-packet counter steps.
  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (pop) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        pkt_d  = pkt_q + CNT_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  // State registers; reset also drops any in-flight word since the FIFO is
  // reset on the same edge.
  always_ff @(posedge rclk) begin
    if (reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      pkt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
    end
  end

  // Stream outputs are taken straight from the buffer head and framing state.
  always_comb begin
    m_valid  = (occ_q != 2'd0);
    m_data   = head_q;
    m_last   = m_valid & (beat_q == LAST_BEAT);
    beat_cnt = beat_q;
    pkt_cnt  = pkt_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and a
// transaction-level model predicts stream contents, framing and read issue.
module tb_fifo_rd_stream;

  localparam int D_WIDTH = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;
  localparam int BEAT_W  = 2;

  logic               rclk = 1'b0;
  logic               reset = 1'b1;
  logic [D_WIDTH-1:0] fifo_rd_data = '0;
  logic               fifo_empty = 1'b1;
  logic               fifo_r_en;
  logic [D_WIDTH-1:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               m_last;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]   pkt_cnt;

  fifo_rd_stream #(.D_WIDTH(D_WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .reset(reset), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 rclk = ~rclk;

  int tests = 0;
  int fails = 0;

  logic [D_WIDTH-1:0] fifo_q[$];
  logic [D_WIDTH-1:0] exp_q[$];
  int beats = 0;
  bit prev_ren = 1'b0;
  bit zero_data = 1'b1;
  int ren_seen = 0;
  int delivered = 0;
  int valid_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [D_WIDTH-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    bit exp_valid, exp_pop, exp_ren;
    int avail;
    @(negedge rclk);
    avail     = exp_q.size() - (prev_ren ? 1 : 0);
    exp_valid = (avail > 0);
    exp_pop   = exp_valid && m_ready && !reset;
    exp_ren   = !reset && (fifo_q.size() > 0) &&
                ((exp_q.size() < 2) || (exp_valid && m_ready));
    chk("m_valid", m_valid, exp_valid);
    chk("fifo_r_en", fifo_r_en, exp_ren);
    chk("beat_cnt", beat_cnt, beats % PKT_LEN);
    chk("pkt_cnt", pkt_cnt, (beats / PKT_LEN) % 65536);
    chk("m_last", m_last, exp_valid && ((beats % PKT_LEN) == PKT_LEN - 1));
    if (exp_valid) chk("m_data", m_data, exp_q[0]);
    else if (zero_data) chk("m_data_rst", m_data, 0);
    if (fifo_r_en) ren_seen++;
    if (m_valid) valid_seen++;
    if (m_valid && m_ready && !reset) delivered++;
    @(posedge rclk);
    #1;
    if (reset) begin
      exp_q.delete();
      fifo_q.delete();
      beats     = 0;
      prev_ren  = 1'b0;
      zero_data = 1'b1;
    end else begin
      if (prev_ren) zero_data = 1'b0;
      if (exp_pop) begin
        void'(exp_q.pop_front());
        beats++;
      end
      if (exp_ren) begin
        fifo_rd_data = fifo_q.pop_front();
        exp_q.push_back(fifo_rd_data);
      end
      prev_ren = exp_ren;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    int n;
    // reset state
    reset = 1'b1; m_ready = 1'b0;
    repeat (2) cycle();
    chk("rst_valid", m_valid, 0);
    chk("rst_ren", fifo_r_en, 0);

    // three words, sink always ready
    reset = 1'b0; m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    ren_seen = 0;
    repeat (8) cycle();
    chk("p1_reads", ren_seen, 3);
    chk("p1_idle_valid", m_valid, 0);

    // two full packets
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    repeat (14) cycle();
    chk("p2_pkt_cnt", pkt_cnt, 2);
    chk("p2_beat_cnt", beat_cnt, 0);

    // backpressure: only two reads, head held
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    ren_seen = 0;
    repeat (6) cycle();
    chk("p3_reads", ren_seen, 2);
    chk("p3_head", m_data, 8'hA0);
    chk("p3_ren_low", fifo_r_en, 0);
    m_ready = 1'b1; valid_seen = 0;
    repeat (5) cycle();
    chk("p3_no_gap", valid_seen, 5);
    repeat (3) cycle();

    // alternating ready
    delivered = 0;
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      m_ready = ~m_ready;
      cycle();
    end
    m_ready = 1'b1;
    repeat (4) cycle();
    chk("p4_delivered", delivered, 6);

    // single word: empty rises right after its read
    delivered = 0; ren_seen = 0;
    push(8'hC5);
    repeat (5) cycle();
    chk("p5_reads", ren_seen, 1);
    chk("p5_delivered", delivered, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 3) != 0) && (fifo_q.size() < 8)) push(8'($urandom));
      m_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    m_ready = 1'b1;
    repeat (20) cycle();
    chk("rand_drained", m_valid, 0);

    // reset mid-packet with a full buffer
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    m_ready = 1'b1;
    n = 0;
    while ((beats != 2) && (n < 20)) begin
      cycle();
      n++;
    end
    m_ready = 1'b0;
    repeat (3) cycle();
    chk("p7_beat_pre", beat_cnt, 2);
    chk("p7_valid_pre", m_valid, 1);
    reset = 1'b1;
    cycle();
    chk("p7_valid", m_valid, 0);
    chk("p7_beat", beat_cnt, 0);
    chk("p7_pkt", pkt_cnt, 0);
    chk("p7_ren", fifo_r_en, 0);
    cycle();
    reset = 1'b0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
